// File: rtl/clk_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// clk_div_pkg: shared constants and helpers for the programmable clock divider.
// rev 1.0
package clk_div_pkg;

  localparam int   MIN_DIV     = 2;
  localparam logic MODE_DUTY50 = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Computed one bit wider than the operand so N = all-ones cannot overflow
  function automatic logic [32:0] half_ceil(input logic [31:0] n);
    return ({1'b0, n} + 33'd1) >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_oddphase.sv
`timescale 1ns/1ps
`default_nettype none
// clk_div_oddphase: falling-edge phase flop and odd/even select for the divider.
// rev 1.0
module clk_div_oddphase (
  input  logic clk_in,
  input  logic reset,
  input  logic p,
  input  logic div_lsb,
  input  logic pulse,
  output logic n,
  output logic odd_sel
);

  // The only negedge-clocked state in the divider; shifts p by half a source cycle
  always_ff @(negedge clk_in or posedge reset) begin
    if (reset) begin
      n <= 1'b0;
    end else begin
      n <= p;
    end
  end

  assign odd_sel = div_lsb & ~pulse;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`timescale 1ns/1ps
`default_nettype none
// clk_div_prog: runtime-programmable integer clock divider, 50 % duty or pulse output.
// rev 1.0
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  input  logic             pulse_mode,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_err
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_pend;
  logic             pend_vld;
  logic             mode_cur;
  logic             en_d;
  logic             p;
  logic             n;
  logic             tick_q;
  logic             err_q;
  logic             odd_sel;
  logic             active;
  logic             wrap;
  logic             apply;
  logic             load_ok;
  logic             load_bad;
  logic             p_next;
  logic [32:0]      half;

  // Running needs en on two consecutive edges, which gives the one-cycle start latency
  assign active   = en & en_d;
  assign wrap     = active & (cnt >= div_cur - WIDTH'(1));
  assign apply    = wrap | ~active;
  assign load_ok  = div_load & (div_val >= WIDTH'(MIN_DIV));
  assign load_bad = div_load & ~load_ok;
  assign half     = half_ceil(32'(div_cur));
  assign p_next   = active & (33'(cnt) < half);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div_cur  <= WIDTH'(DEFAULT_DIV);
      div_pend <= '0;
      pend_vld <= 1'b0;
      mode_cur <= MODE_DUTY50;
      en_d     <= 1'b0;
      p        <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_d   <= en;
      cnt    <= (active && !wrap) ? cnt + WIDTH'(1) : '0;
      p      <= p_next;
      tick_q <= active & (cnt == '0);
      err_q  <= load_bad;
      // Divisor and mode only change on a period boundary (or while stopped)
      if (apply) begin
        mode_cur <= pulse_mode;
        pend_vld <= 1'b0;
        if (load_ok) begin
          div_cur <= div_val;
        end else if (pend_vld) begin
          div_cur <= div_pend;
        end
      end else if (load_ok) begin
        div_pend <= div_val;
        pend_vld <= 1'b1;
      end
    end
  end

  clk_div_oddphase u_oddphase (
    .clk_in  (clk_in),
    .reset   (reset),
    .p       (p),
    .div_lsb (div_cur[0]),
    .pulse   (mode_cur),
    .n       (n),
    .odd_sel (odd_sel)
  );

  // Pulse output shares the tick flop: both are the registered start-of-period strobe
  assign clk_out = (mode_cur == MODE_PULSE) ? tick_q
                 : (odd_sel ? (p & n) : p);
  assign tick    = tick_q;
  assign div_err = err_q;

endmodule
`default_nettype wire
